ternary_dot_mac: RTL and testbench

TERNARY_DOT_MAC -- requirements
Module: ternary_dot_mac

---
 rtl/ternary_dot_mac.sv | 178 +++++++++++++++++
 tb/tb_ternary_dot_mac.sv | 313 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ternary_dot_mac.sv
// Balanced-ternary dot-product MAC: LANES trit-weighted activations summed per beat.
// Define TERNARY_DOT_MAC_SAT_EN to clamp on overflow instead of wrapping.
package ternary_dot_mac_pkg;
  typedef logic [1:0] trit_t;
  localparam trit_t T_NEG  = 2'b00;
  localparam trit_t T_ZERO = 2'b01;
  localparam trit_t T_POS  = 2'b10;
endpackage

module ternary_dot_mac
  import ternary_dot_mac_pkg::*;
#(
  parameter int LANES     = 4,
  parameter int ACT_WIDTH = 8,
  parameter int ACC_WIDTH = 27,
  parameter int LEN_WIDTH = 8
) (
  input  logic                                clk,
  input  logic                                rst_n,
  input  logic                                start,
  input  logic [LEN_WIDTH-1:0]                cfg_len,
  input  trit_t [ACC_WIDTH-1:0]               bias,
  input  logic                                in_valid,
  output logic                                in_ready,
  input  trit_t [LANES-1:0][ACT_WIDTH-1:0]    activation,
  input  logic [LANES-1:0][1:0]               weight,
  output logic                                out_valid,
  input  logic                                out_ready,
  output trit_t [ACC_WIDTH-1:0]               acc_out,
  output logic [LEN_WIDTH+$clog2(LANES+1)-1:0] skip_cnt,
  output logic                                overflow,
  output logic                                busy
);

  localparam int ZW = $clog2(LANES + 1);
  localparam int SW = LEN_WIDTH + ZW;
  localparam int CW = ZW + 2;

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_ACCUM = 2'd1;
  localparam logic [1:0] S_DONE  = 2'd2;

  // Internal digits are 2-bit two's complement: -1=11, 0=00, +1=01.
  typedef logic [ACC_WIDTH-1:0][1:0] dvec_t;

  function automatic logic [1:0] t2d(input trit_t t);
    logic [1:0] d;
    case (t)
      T_NEG:   d = 2'b11;
      T_POS:   d = 2'b01;
      default: d = 2'b00;
    endcase
    return d;
  endfunction

  function automatic logic [2*ACC_WIDTH+1:0] bt_add(
    input dvec_t a,
    input dvec_t b
  );
    dvec_t s;
    logic signed [2:0] c;
    logic signed [2:0] t;
    c = '0;
    for (int i = 0; i < ACC_WIDTH; i++) begin
      t = $signed({a[i][1], a[i]}) + $signed({b[i][1], b[i]}) + c;
      if (t > 3'sd1) begin
        c = 3'sd1;
        t = t - 3'sd3;
      end else if (t < -3'sd1) begin
        c = -3'sd1;
        t = t + 3'sd3;
      end else begin
        c = '0;
      end
      s[i] = t[1:0];
    end
    return {c[1:0], s};
  endfunction

  logic [1:0]           state;
  logic [LEN_WIDTH-1:0] cnt;
  dvec_t                acc_q;
  dvec_t                acc_d;
  dvec_t                bias_d;
  dvec_t [LANES-1:0]    prod;
  dvec_t [LANES:0]      part;
  logic [LANES-1:0][1:0] cout;
  logic [CW-1:0]        csum;
  logic [ZW-1:0]        zcnt;
  logic                 ovf_beat;

  always_comb begin
    zcnt = '0;
    for (int l = 0; l < LANES; l++) begin
      prod[l] = '0;
      unique case (1'b1)
        weight[l] == 2'b10:
          for (int i = 0; i < ACT_WIDTH; i++)
            prod[l][i] = t2d(activation[l][i]);
        weight[l] == 2'b00:
          for (int i = 0; i < ACT_WIDTH; i++)
            prod[l][i] = 2'b00 - t2d(activation[l][i]);
        default: zcnt = zcnt + ZW'(1);
      endcase
    end
  end

  // Exact sum = wrapped sum + csum * 3^ACC_WIDTH, so any carry-out means overflow.
  always_comb begin
    part = '0;
    cout = '0;
    csum = '0;
    part[0] = acc_q;
    for (int l = 0; l < LANES; l++) begin
      {cout[l], part[l+1]} = bt_add(part[l], prod[l]);
      csum = csum + {{(CW-2){cout[l][1]}}, cout[l]};
    end
    ovf_beat = |csum;
`ifdef TERNARY_DOT_MAC_SAT_EN
    if (ovf_beat)
      acc_d = csum[CW-1] ? {ACC_WIDTH{2'b11}} : {ACC_WIDTH{2'b01}};
    else
      acc_d = part[LANES];
`else
    acc_d = part[LANES];
`endif
  end

  always_comb begin
    for (int i = 0; i < ACC_WIDTH; i++) begin
      bias_d[i]  = t2d(bias[i]);
      acc_out[i] = trit_t'(acc_q[i] + 2'd1);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state    <= S_IDLE;
      cnt      <= '0;
      acc_q    <= '0;
      skip_cnt <= '0;
      overflow <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (start) begin
            acc_q    <= bias_d;
            cnt      <= cfg_len;
            skip_cnt <= '0;
            overflow <= 1'b0;
            state    <= (cfg_len == '0) ? S_DONE : S_ACCUM;
          end
        end
        S_ACCUM: begin
          if (in_valid) begin
            acc_q    <= acc_d;
            cnt      <= cnt - LEN_WIDTH'(1);
            skip_cnt <= skip_cnt + SW'(zcnt);
            if (ovf_beat)
              overflow <= 1'b1;
            if (cnt == LEN_WIDTH'(1))
              state <= S_DONE;
          end
        end
        S_DONE: begin
          if (out_ready)
            state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  assign in_ready  = (state == S_ACCUM);
  assign out_valid = (state == S_DONE);
  assign busy      = (state != S_IDLE);

endmodule

// File: tb/tb_ternary_dot_mac.sv
// Scoreboard bench for ternary_dot_mac: integer reference model, random and edge jobs.
// Honours TERNARY_DOT_MAC_SAT_EN for the expected overflow behaviour.
module tb_ternary_dot_mac;

  localparam longint M = 64'sd3812798742493;
  localparam longint P = 64'sd7625597484987;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         start = 1'b0;
  logic [7:0]   cfg_len = '0;
  logic [53:0]  bias = '0;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [3:0][15:0] activation = '0;
  logic [3:0][1:0]  weight = '0;
  logic         out_valid;
  logic         out_ready = 1'b1;
  logic [53:0]  acc_out;
  logic [10:0]  skip_cnt;
  logic         overflow;
  logic         busy;

  ternary_dot_mac dut (
    .clk(clk), .rst_n(rst_n), .start(start), .cfg_len(cfg_len),
    .bias(bias), .in_valid(in_valid), .in_ready(in_ready),
    .activation(activation), .weight(weight), .out_valid(out_valid),
    .out_ready(out_ready), .acc_out(acc_out), .skip_cnt(skip_cnt),
    .overflow(overflow), .busy(busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    longint acc;
    longint skip;
    longint ovf;
  } exp_t;

  exp_t   exp_q[$];
  int     checks = 0;
  int     errors = 0;
  longint m_acc, m_skip, m_ovf;
  longint cur_act[4];
  logic [1:0] cur_w[4];

  task automatic chk(input string name, input longint act, input longint req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d at %0t", name, act, req, $time);
    end
  endtask

  function automatic logic [53:0] enc(input longint v);
    logic [53:0] r;
    longint x;
    longint d;
    x = v;
    for (int i = 0; i < 27; i++) begin
      d = x % 3;
      if (d < 0) d += 3;
      if (d == 2) d = -1;
      x = (x - d) / 3;
      r[2*i+:2] = (d == 1) ? 2'b10 : (d == -1) ? 2'b00 : 2'b01;
    end
    return r;
  endfunction

  function automatic longint dec(input logic [53:0] x);
    longint v = 0;
    for (int i = 26; i >= 0; i--)
      v = v * 3 + ((x[2*i+:2] == 2'b10) ? 1 : (x[2*i+:2] == 2'b00) ? -1 : 0);
    return v;
  endfunction

  function automatic longint bad_trits(input logic [53:0] x);
    longint n = 0;
    for (int i = 0; i < 27; i++)
      if (x[2*i+:2] == 2'b11) n++;
    return n;
  endfunction

  // Reference: exact integer dot product, then range rule.
  task automatic model_beat();
    longint s = m_acc;
    for (int l = 0; l < 4; l++) begin
      if (cur_w[l] == 2'b10) s += cur_act[l];
      else if (cur_w[l] == 2'b00) s -= cur_act[l];
      else m_skip++;
    end
    if (s > M || s < -M) begin
      m_ovf = 1;
`ifdef TERNARY_DOT_MAC_SAT_EN
      s = (s > 0) ? M : -M;
`else
      s = ((s + M) % P + P) % P - M;
`endif
    end
    m_acc = s;
  endtask

  task automatic push_exp();
    exp_t e;
    e.acc = m_acc;
    e.skip = m_skip;
    e.ovf = m_ovf;
    exp_q.push_back(e);
  endtask

  always @(negedge clk) begin
    if (rst_n && out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_result", dec(acc_out), 0);
        chk("unexpected_valid", 1, 0);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        chk("acc_out", dec(acc_out), e.acc);
        chk("skip_cnt", longint'(skip_cnt), e.skip);
        chk("overflow", longint'(overflow), e.ovf);
        chk("acc_enc", bad_trits(acc_out), 0);
      end
    end
  end

  task automatic reset_checks(input string tag);
    @(negedge clk);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_in_ready"}, in_ready, 0);
    chk({tag, "_out_valid"}, out_valid, 0);
    chk({tag, "_acc_raw"}, longint'(acc_out == {27{2'b01}}), 1);
    chk({tag, "_skip"}, longint'(skip_cnt), 0);
    chk({tag, "_ovf"}, longint'(overflow), 0);
  endtask

  task automatic start_job(input longint b, input int len);
    bias = enc(b);
    cfg_len = len[7:0];
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    m_acc = b;
    m_skip = 0;
    m_ovf = 0;
  endtask

  task automatic beat(input bit v, output bit took);
    logic [53:0] tmp;
    bit rdy;
    for (int l = 0; l < 4; l++) begin
      tmp = enc(cur_act[l]);
      activation[l] = tmp[15:0];
      weight[l] = cur_w[l];
    end
    in_valid = v;
    // A start raised mid-job must be ignored.
    if (v && $urandom_range(0, 3) == 0) begin
      start = 1'b1;
      cfg_len = 8'($urandom);
    end
    @(negedge clk);
    rdy = in_ready;
    @(posedge clk); #1;
    in_valid = 1'b0;
    start = 1'b0;
    if (v) chk("in_ready", rdy, 1);
    took = v && rdy;
    if (took) model_beat();
  endtask

  task automatic rand_data();
    for (int l = 0; l < 4; l++) begin
      cur_act[l] = longint'($urandom_range(0, 6560)) - 3280;
      cur_w[l] = 2'($urandom_range(0, 3));
    end
  endtask

  function automatic longint rand_bias();
    logic [63:0] r;
    longint v;
    r = {$urandom, $urandom};
    if ($urandom_range(0, 3) == 0) begin
      v = M - longint'($urandom_range(0, 40000));
      if ($urandom_range(0, 1) == 1) v = -v;
    end else begin
      v = longint'(r % 64'(2 * M + 1)) - M;
    end
    return v;
  endfunction

  task automatic wait_idle(input bit rnd);
    bit done = 0;
    for (int c = 0; c < 300 && !done; c++) begin
      @(posedge clk); #1;
      out_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      @(negedge clk);
      if (!busy && exp_q.size() == 0) done = 1;
    end
    out_ready = 1'b1;
    if (!done) chk("job_timeout", 1, 0);
  endtask

  task automatic run_job(input longint b, input int len, input bit rnd);
    int got = 0;
    bit took;
    start_job(b, len);
    while (got < len) begin
      if (rnd) rand_data();
      beat(rnd ? ($urandom_range(0, 3) != 0) : 1'b1, took);
      if (took) got++;
    end
    push_exp();
    wait_idle(rnd);
  endtask

  initial begin
    bit took;
    repeat (2) @(posedge clk);
    #1;
    reset_checks("reset");
    rst_n = 1'b1;

    // Single beat with a mix of +1, -1, 0 weights and one-cycle latency.
    cur_act = '{10, 20, 15, 5};
    cur_w = '{2'b10, 2'b00, 2'b01, 2'b10};
    start_job(100, 1);
    beat(1, took);
    push_exp();
    @(negedge clk);
    chk("latency_valid", out_valid, 1);
    @(posedge clk); #1;
    @(negedge clk);
    chk("idle_busy", busy, 0);
    chk("idle_acc", dec(acc_out), 95);
    chk("idle_skip", longint'(skip_cnt), 1);
    // Beats offered in IDLE change nothing.
    in_valid = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    in_valid = 1'b0;
    @(negedge clk);
    chk("idle_inv_busy", busy, 0);
    chk("idle_inv_acc", dec(acc_out), 95);

    // Zero-length job with back-pressure.
    @(posedge clk); #1;
    out_ready = 1'b0;
    start_job(-42, 0);
    push_exp();
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("hold_valid", out_valid, 1);
      chk("hold_acc", dec(acc_out), -42);
      @(posedge clk); #1;
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    @(negedge clk);
    chk("release_valid", out_valid, 0);
    chk("release_busy", busy, 0);

    // Gapped beats at maximum activation.
    cur_act = '{3280, 3280, 3280, 3280};
    cur_w = '{2'b10, 2'b10, 2'b10, 2'b10};
    start_job(0, 3);
    beat(1, took);
    beat(0, took);
    beat(1, took);
    beat(0, took);
    beat(1, took);
    push_exp();
    wait_idle(0);
    chk("gap_acc", dec(acc_out), 39360);

    // Positive overflow at the range edge.
    cur_act = '{1, 0, 0, 0};
    cur_w = '{2'b10, 2'b01, 2'b01, 2'b01};
    start_job(M, 1);
    beat(1, took);
    push_exp();
    wait_idle(0);
    chk("edge_ovf", longint'(overflow), 1);
`ifdef TERNARY_DOT_MAC_SAT_EN
    chk("edge_acc", dec(acc_out), M);
`else
    chk("edge_acc", dec(acc_out), -M);
`endif

    // Reset during the second of four beats abandons the job.
    rand_data();
    start_job(5, 4);
    beat(1, took);
    in_valid = 1'b1;
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    in_valid = 1'b0;
    reset_checks("midrst");
    repeat (4) @(posedge clk);
    #1;
    rand_data();
    run_job(rand_bias(), 1, 0);

    for (int j = 0; j < 40; j++)
      run_job(rand_bias(), $urandom_range(1, 20), 1);

    chk("queue_empty", exp_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
